fft_frame_arbiter: RTL
======================

FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FFT, 2..8.
REQ-002 Parameter DATA_WIDTH, default 16: sample component width.
REQ-003 Parameter FFT_SIZE, default 512: samples per frame; address width 9.
REQ-004 Parameter TIMEOUT_CYC, default 8192: max COMPUTE cycles before abort.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req  in  NUM_REQ  per-requester frame request, level.
REQ-009 grant  out  NUM_REQ  one-hot owner of the FFT; zero when idle.
REQ-010 src_real, src_imag  in  NUM_REQ*DATA_WIDTH each  packed per-requester sample, slot i at bits [i*DW +: DW].
REQ-011 src_valid  in  NUM_REQ  per-requester sample valid.
REQ-012 src_ready  out  NUM_REQ  sample accept; only the granted bit may be 1.
REQ-013 fft_start  out  1  one-cycle FFT start pulse.
REQ-014 fft_in_real, fft_in_imag  out  DATA_WIDTH  sample to FFT.
REQ-015 fft_in_addr  out  9  natural-order sample index.
REQ-016 fft_in_valid  out  1  sample strobe to FFT.
REQ-017 fft_busy, fft_done  in  1 each  FFT status; fft_done is a one-cycle pulse.
REQ-018 fft_out_real, fft_out_imag, fft_out_addr, fft_out_valid  in  DW/DW/9/1  FFT result beat.
REQ-019 res_real, res_imag, res_addr  out  DW/DW/9  forwarded result beat.
REQ-020 res_valid  out  NUM_REQ  one-hot result strobe to the frame owner.
REQ-021 frame_done  out  NUM_REQ  one-cycle pulse to owner at frame end.
REQ-022 err_timeout  out  1  one-cycle pulse on COMPUTE timeout; err_id  out  3  owner index at abort.

Function
REQ-023 States: ARB, START, LOAD, COMPUTE, DRAIN; all outputs registered.
REQ-024 ARB: when fft_busy=0 and req!=0, grant requester found by round-robin search starting at last_owner+1 (wrapping), go to START; otherwise stay, grant=0.
REQ-025 last_owner resets to NUM_REQ-1, so requester 0 wins first after reset.
REQ-026 START: fft_start=1 for exactly this cycle; next state LOAD; sample counter cleared to 0.
REQ-027 LOAD: src_ready[owner]=1; beat accepted when src_valid[owner]&src_ready[owner]; next cycle fft_in_valid=1, fft_in_addr=counter, data=owner's slot; counter +1 per beat.
REQ-028 Beat with counter FFT_SIZE-1 ends LOAD: src_ready drops the following cycle, state COMPUTE; no further samples accepted.
REQ-029 src_valid gaps in LOAD: fft_in_valid=0 that cycle, counter holds; no timeout in LOAD.
REQ-030 Deasserting req after grant does not abort; frame completes.
REQ-031 COMPUTE: cycle counter from 0; fft_done -> DRAIN; counter reaching TIMEOUT_CYC-1 without fft_done -> err_timeout=1, err_id=owner, frame_done not pulsed, state ARB.
REQ-032 Result forwarding in COMPUTE and DRAIN: each fft_out_valid beat appears 1 cycle later on res_* with res_valid[owner]=1, other bits 0.
REQ-033 DRAIN: first cycle with fft_out_valid=0 -> frame_done[owner]=1, grant=0, last_owner=owner, state ARB.
REQ-034 fft_done and fft_out_valid in same cycle: beat forwarded, DRAIN entered.
REQ-035 fft_out_valid in ARB/START/LOAD ignored; res_valid stays 0.
REQ-036 Timeout abort also updates last_owner=owner.
REQ-037 Unused/no-owner: src_ready=0, res_valid=0.

Reset
REQ-038 rst=1 at any state, including mid-LOAD: next cycle state ARB, grant=0, src_ready=0, fft_start=0, fft_in_valid=0, fft_in_addr=0, fft_in_real/imag=0, res_*=0, res_valid=0, frame_done=0, err_timeout=0, err_id=0, counters 0, last_owner=NUM_REQ-1.

Verification
REQ-039 req=4'b0101 from reset -> grant=0001, fft_start pulse 1 cycle; after frame done, grant=0100.
REQ-040 Owner streams 512 beats, valid held -> fft_in_addr 0..511 contiguous, fft_in_valid 512 cycles, src_ready low after beat 511.
REQ-041 src_valid toggled 1/0 each cycle -> 512 beats, addresses contiguous, no duplication.
REQ-042 fft_done plus 512 fft_out_valid beats -> res_valid[owner] 512 beats 1 cycle delayed, frame_done[owner] one pulse on first idle cycle.
REQ-043 No fft_done in COMPUTE -> err_timeout pulse after TIMEOUT_CYC cycles, err_id=owner, frame_done silent, next requester granted.
REQ-044 rst asserted at LOAD beat 200 -> all outputs zero next cycle; req held gives fresh grant to requester 0 with addr restarting at 0.

Source files
------------

// File: rtl/fft_frame_arbiter_if.sv
// Bundles the requester, FFT-facing and result-facing signals of fft_frame_arbiter.
// The arbiter uses the slave modport; the environment (requesters + FFT core) uses master.
interface fft_frame_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ*DATA_WIDTH-1:0] src_real;
    logic [NUM_REQ*DATA_WIDTH-1:0] src_imag;
    logic [NUM_REQ-1:0]            src_valid;
    logic [NUM_REQ-1:0]            src_ready;
    logic                          fft_start;
    logic [DATA_WIDTH-1:0]         fft_in_real;
    logic [DATA_WIDTH-1:0]         fft_in_imag;
    logic [ADDR_WIDTH-1:0]         fft_in_addr;
    logic                          fft_in_valid;
    logic                          fft_busy;
    logic                          fft_done;
    logic [DATA_WIDTH-1:0]         fft_out_real;
    logic [DATA_WIDTH-1:0]         fft_out_imag;
    logic [ADDR_WIDTH-1:0]         fft_out_addr;
    logic                          fft_out_valid;
    logic [DATA_WIDTH-1:0]         res_real;
    logic [DATA_WIDTH-1:0]         res_imag;
    logic [ADDR_WIDTH-1:0]         res_addr;
    logic [NUM_REQ-1:0]            res_valid;
    logic [NUM_REQ-1:0]            frame_done;
    logic                          err_timeout;
    logic [2:0]                    err_id;

    modport master (
        output req, src_real, src_imag, src_valid, fft_busy, fft_done,
               fft_out_real, fft_out_imag, fft_out_addr, fft_out_valid,
        input  grant, src_ready, fft_start, fft_in_real, fft_in_imag, fft_in_addr,
               fft_in_valid, res_real, res_imag, res_addr, res_valid, frame_done,
               err_timeout, err_id
    );

    modport slave (
        input  req, src_real, src_imag, src_valid, fft_busy, fft_done,
               fft_out_real, fft_out_imag, fft_out_addr, fft_out_valid,
        output grant, src_ready, fft_start, fft_in_real, fft_in_imag, fft_in_addr,
               fft_in_valid, res_real, res_imag, res_addr, res_valid, frame_done,
               err_timeout, err_id
    );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Round-robin arbiter sharing one FFT core among NUM_REQ frame requesters: loads the owner's
// frame, watches the compute phase with a timeout, and forwards result beats back to the owner.
module fft_frame_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FFT_SIZE    = 512,
    parameter int unsigned TIMEOUT_CYC = 8192
) (
    input logic                clk,
    input logic                rst,
    fft_frame_arbiter_if.slave bus_io
);
    localparam int unsigned AddrWidth = 9;
    localparam int unsigned CycWidth  = $clog2(TIMEOUT_CYC);
    localparam logic [AddrWidth-1:0] LastBeat = AddrWidth'(FFT_SIZE - 1);
    localparam logic [CycWidth-1:0]  LastCyc  = CycWidth'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {StArb, StStart, StLoad, StCompute, StDrain} state_e;

    state_e                state_q, state_d;
    logic [2:0]            owner_q, owner_d, last_owner_q, last_owner_d;
    logic [AddrWidth-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CycWidth-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d, src_ready_q, src_ready_d;
    logic [NUM_REQ-1:0]    res_valid_q, res_valid_d, frame_done_q, frame_done_d;
    logic                  fft_start_q, fft_start_d, fft_in_valid_q, fft_in_valid_d;
    logic                  err_timeout_q, err_timeout_d;
    logic [2:0]            err_id_q, err_id_d;
    logic [DATA_WIDTH-1:0] fft_in_real_q, fft_in_real_d, fft_in_imag_q, fft_in_imag_d;
    logic [DATA_WIDTH-1:0] res_real_q, res_real_d, res_imag_q, res_imag_d;
    logic [AddrWidth-1:0]  fft_in_addr_q, fft_in_addr_d, res_addr_q, res_addr_d;

    logic [NUM_REQ-1:0]    owner_oh;
    logic [DATA_WIDTH-1:0] owner_real, owner_imag;
    logic                  beat_accept;
    logic [2:0]            rr_winner;
    logic                  rr_found;

    assign owner_oh    = NUM_REQ'(1) << owner_q;
    assign owner_real  = DATA_WIDTH'(bus_io.src_real >> (32'(owner_q) * DATA_WIDTH));
    assign owner_imag  = DATA_WIDTH'(bus_io.src_imag >> (32'(owner_q) * DATA_WIDTH));
    assign beat_accept = |(bus_io.src_valid & src_ready_q & owner_oh);

    // Search starts just past the previous owner so every requester gets a turn.
    always_comb begin
        logic [NUM_REQ-1:0] req_sh;
        int unsigned        idx;
        rr_winner = '0;
        rr_found  = 1'b0;
        req_sh    = '0;
        idx       = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx    = (32'(last_owner_q) + i) % NUM_REQ;
            req_sh = bus_io.req >> idx;
            if (!rr_found && req_sh[0]) begin
                rr_found  = 1'b1;
                rr_winner = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        beat_cnt_d     = beat_cnt_q;
        cyc_cnt_d      = cyc_cnt_q;
        grant_d        = grant_q;
        src_ready_d    = src_ready_q;
        fft_start_d    = 1'b0;
        fft_in_valid_d = 1'b0;
        fft_in_addr_d  = fft_in_addr_q;
        fft_in_real_d  = fft_in_real_q;
        fft_in_imag_d  = fft_in_imag_q;
        res_valid_d    = '0;
        res_real_d     = res_real_q;
        res_imag_d     = res_imag_q;
        res_addr_d     = res_addr_q;
        frame_done_d   = '0;
        err_timeout_d  = 1'b0;
        err_id_d       = err_id_q;

        if ((state_q == StCompute || state_q == StDrain) && bus_io.fft_out_valid) begin
            res_valid_d = owner_oh;
            res_real_d  = bus_io.fft_out_real;
            res_imag_d  = bus_io.fft_out_imag;
            res_addr_d  = bus_io.fft_out_addr;
        end

        unique case (state_q)
            StArb: begin
                if (!bus_io.fft_busy && rr_found) begin
                    owner_d     = rr_winner;
                    grant_d     = NUM_REQ'(1) << rr_winner;
                    fft_start_d = 1'b1;
                    state_d     = StStart;
                end
            end
            StStart: begin
                beat_cnt_d  = '0;
                src_ready_d = owner_oh;
                state_d     = StLoad;
            end
            StLoad: begin
                if (beat_accept) begin
                    fft_in_valid_d = 1'b1;
                    fft_in_addr_d  = beat_cnt_q;
                    fft_in_real_d  = owner_real;
                    fft_in_imag_d  = owner_imag;
                    beat_cnt_d     = beat_cnt_q + AddrWidth'(1);
                    if (beat_cnt_q == LastBeat) begin
                        src_ready_d = '0;
                        cyc_cnt_d   = '0;
                        state_d     = StCompute;
                    end
                end
            end
            StCompute: begin
                if (bus_io.fft_done) begin
                    state_d = StDrain;
                end else if (cyc_cnt_q == LastCyc) begin
                    err_timeout_d = 1'b1;
                    err_id_d      = owner_q;
                    grant_d       = '0;
                    last_owner_d  = owner_q;
                    state_d       = StArb;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CycWidth'(1);
                end
            end
            StDrain: begin
                if (!bus_io.fft_out_valid) begin
                    frame_done_d = owner_oh;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    state_d      = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StArb;
            owner_q        <= '0;
            last_owner_q   <= 3'(NUM_REQ - 1);
            beat_cnt_q     <= '0;
            cyc_cnt_q      <= '0;
            grant_q        <= '0;
            src_ready_q    <= '0;
            fft_start_q    <= 1'b0;
            fft_in_valid_q <= 1'b0;
            fft_in_addr_q  <= '0;
            fft_in_real_q  <= '0;
            fft_in_imag_q  <= '0;
            res_valid_q    <= '0;
            res_real_q     <= '0;
            res_imag_q     <= '0;
            res_addr_q     <= '0;
            frame_done_q   <= '0;
            err_timeout_q  <= 1'b0;
            err_id_q       <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_owner_q   <= last_owner_d;
            beat_cnt_q     <= beat_cnt_d;
            cyc_cnt_q      <= cyc_cnt_d;
            grant_q        <= grant_d;
            src_ready_q    <= src_ready_d;
            fft_start_q    <= fft_start_d;
            fft_in_valid_q <= fft_in_valid_d;
            fft_in_addr_q  <= fft_in_addr_d;
            fft_in_real_q  <= fft_in_real_d;
            fft_in_imag_q  <= fft_in_imag_d;
            res_valid_q    <= res_valid_d;
            res_real_q     <= res_real_d;
            res_imag_q     <= res_imag_d;
            res_addr_q     <= res_addr_d;
            frame_done_q   <= frame_done_d;
            err_timeout_q  <= err_timeout_d;
            err_id_q       <= err_id_d;
        end
    end

    assign bus_io.grant        = grant_q;
    assign bus_io.src_ready    = src_ready_q;
    assign bus_io.fft_start    = fft_start_q;
    assign bus_io.fft_in_valid = fft_in_valid_q;
    assign bus_io.fft_in_addr  = fft_in_addr_q;
    assign bus_io.fft_in_real  = fft_in_real_q;
    assign bus_io.fft_in_imag  = fft_in_imag_q;
    assign bus_io.res_valid    = res_valid_q;
    assign bus_io.res_real     = res_real_q;
    assign bus_io.res_imag     = res_imag_q;
    assign bus_io.res_addr     = res_addr_q;
    assign bus_io.frame_done   = frame_done_q;
    assign bus_io.err_timeout  = err_timeout_q;
    assign bus_io.err_id       = err_id_q;
endmodule
